// File: rtl/sa_pkg.sv
// Shared defaults and types for the systolic-array result drain.
package sa_pkg;
  localparam int SA_ROWS = 8;
  localparam int SA_DW   = 32;
  localparam int SA_CNTW = 16;
  localparam int SA_RW   = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1;

  typedef logic [SA_RW-1:0] row_t;
  typedef logic [SA_DW-1:0] word_t;

  // The encoding is kept explicit so it lines up with older tooling.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;
endpackage

// File: rtl/sa_vec_pingpong.sv
// Two-entry result-vector store with full flags and in-order write/read pointers.
// A write strobe must only be raised when the entry at wr_ptr is empty.
// A release strobe must only be raised when the entry at rd_ptr is full.
module sa_vec_pingpong
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int DW   = SA_DW,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [0:ROWS-1][DW-1:0]  wr_data,
  input  logic                     rel,
  input  logic [RW-1:0]            rd_row,
  output logic [1:0]               full,
  output logic                     wr_ptr,
  output logic                     rd_ptr,
  output logic [DW-1:0]            rd_data
);

  logic [1:0][0:ROWS-1][DW-1:0] mem;

  // Storage is cleared on reset so the read mux never shows X.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      mem <= '0;
    else if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Capture and release always target different entries, so they are independent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_en) begin
        full[wr_ptr] <= 1'b1;
        wr_ptr       <= ~wr_ptr;
      end
      if (rel) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
    end
  end

  assign rd_data = mem[rd_ptr][rd_row];

endmodule

// File: rtl/sa_result_drain.sv
// Drains completed SA_CORE result vectors into a ping-pong buffer and
// serialises them row by row onto a valid/ready stream.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int ROWS = SA_ROWS,
  parameter int DW   = SA_DW,
  parameter int CNTW = SA_CNTW
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [0:ROWS-1][DW-1:0]     res_in,
  input  logic [0:ROWS-1]             res_valid,
  output logic                        res_read,
  output logic [DW-1:0]               out_data,
  output logic [$clog2(ROWS)-1:0]     out_row,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CNTW-1:0]             vec_count,
  output logic                        busy
);

  localparam int RW = $clog2(ROWS);

  logic [1:0]    full;
  logic          wr_ptr, rd_ptr;
  logic [DW-1:0] rd_word;
  ser_state_e    state;
  logic [RW-1:0] row_idx;
  logic          last, fire, rel, cap_rd, other_next;

  // A release in the same cycle is deliberately not considered: capture waits a cycle.
  assign res_read   = rstn & (&res_valid) & ~full[wr_ptr];

  assign last       = (row_idx == RW'(ROWS - 1));
  assign out_valid  = (state == STREAM);
  assign fire       = out_valid & out_ready;
  assign rel        = fire & last;
  assign out_data   = out_valid ? rd_word : '0;
  assign out_row    = row_idx;
  assign out_last   = out_valid & last;
  assign busy       = |full;

  // Capture landing in the entry the serialiser reads next (only when both are empty).
  assign cap_rd     = res_read & (wr_ptr == rd_ptr);
  // The other entry holds data after this edge: already full, or being captured now.
  // Counting the in-flight capture keeps back-to-back vectors gapless.
  assign other_next = full[~rd_ptr] | (res_read & (wr_ptr != rd_ptr));

  sa_vec_pingpong #(.ROWS(ROWS), .DW(DW), .RW(RW)) u_pp (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (res_read),
    .wr_data (res_in),
    .rel     (rel),
    .rd_row  (row_idx),
    .full    (full),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_word)
  );

  // Serialiser FSM, row counter and emitted-vector counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      row_idx   <= '0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE:    if (full[rd_ptr] | cap_rd) state <= STREAM;
        STREAM:  if (fire) begin
                   row_idx <= last ? '0 : row_idx + 1'b1;
                   if (last) begin
                     vec_count <= vec_count + 1'b1;
                     if (!other_next) state <= IDLE;
                   end
                 end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain: directed scenarios plus a randomized phase,
// all checked against a queue-of-vectors reference model.
module tb_sa_result_drain;
  localparam int ROWS = 8;
  localparam int DW   = 32;
  localparam int CNTW = 16;
  typedef logic [0:ROWS-1][DW-1:0] vec_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  vec_t              res_in = '0;
  logic [0:ROWS-1]   res_valid = '0;
  logic              res_read;
  logic [DW-1:0]     out_data;
  logic [2:0]        out_row;
  logic              out_last, out_valid;
  logic              out_ready = 1'b0;
  logic [CNTW-1:0]   vec_count;
  logic              busy;

  int   total = 0, bad = 0;
  // Reference model: buffered vectors in arrival order, position in the head one.
  vec_t mq[$];
  int   mpos = 0, mcnt = 0, beats = 0;
  bit   took = 0;
  logic ov_s;

  sa_result_drain dut (
    .clk(clk), .rstn(rstn), .res_in(res_in), .res_valid(res_valid),
    .res_read(res_read), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .vec_count(vec_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT to model, take the edge, advance the model.
  task automatic cyc();
    bit exp_rr, exp_ov, fire;
    #1;
    exp_rr = (&res_valid) && (mq.size() < 2);
    exp_ov = (mq.size() > 0);
    ov_s   = out_valid;
    chk("res_read", res_read, exp_rr);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_data", out_data, mq[0][mpos]);
      chk("out_row", out_row, mpos);
      chk("out_last", out_last, mpos == ROWS - 1);
    end
    chk("vec_count", vec_count, mcnt % (1 << CNTW));
    chk("busy", busy, mq.size() > 0);
    fire = exp_ov && out_ready;
    @(posedge clk);
    if (fire) begin
      beats++;
      mpos++;
      if (mpos == ROWS) begin
        mpos = 0;
        void'(mq.pop_front());
        mcnt++;
      end
    end
    if (exp_rr) mq.push_back(res_in);
    took = exp_rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    res_valid = '0;
    rstn = 1'b0;
    mq.delete(); mpos = 0; mcnt = 0;
    #2 rstn = 1'b1;
    @(negedge clk);
  endtask

  // Present a full vector until the model says it is taken (bounded).
  task automatic offer(input vec_t v, input int bound, output int n);
    res_in = v; res_valid = '1; n = 0;
    do begin cyc(); n++; end while (!took && n < bound);
    res_valid = '0;
    chk("offer_taken", took, 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    out_ready = 1'b1;
    while (mq.size() > 0 && n < bound) begin cyc(); n++; end
    chk("drain_empty", busy, 0);
  endtask

  function automatic vec_t seq_vec(input int base);
    vec_t v;
    for (int r = 0; r < ROWS; r++) v[r] = DW'(base + r);
    return v;
  endfunction

  initial begin
    int n, gaps, b0;
    vec_t v;

    // Reset held with all rows valid: nothing moves.
    res_valid = '1;
    #2;
    chk("rst_res_read", res_read, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vec_count", vec_count, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_last", out_last, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_hold_read", res_read, 0);
      chk("rst_hold_busy", busy, 0);
    end
    do_reset();

    // Single vector with ready high.
    out_ready = 1'b1;
    offer(seq_vec(100), 4, n);
    chk("t2_lat", n, 1);
    for (int i = 0; i < 9; i++) cyc();
    chk("t2_count", vec_count, 1);
    chk("t2_busy", busy, 0);

    // Partial valid never captures.
    res_valid = 8'h7F;
    for (int i = 0; i < 10; i++) cyc();
    chk("t3_out_valid", out_valid, 0);
    chk("t3_count", vec_count, 1);
    res_valid = '0;
    do_reset();

    // Backpressure: A and B buffered, C stalled until A leaves.
    out_ready = 1'b0;
    offer(seq_vec(1), 4, n);
    offer(seq_vec(11), 4, n);
    res_in = seq_vec(21); res_valid = '1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_stall_data", out_data, 1);
    end
    out_ready = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!took && n < 20);
    chk("t4_c_lat", n, 9);
    res_valid = '0;
    drain(40);
    chk("t4_count", vec_count, 3);
    do_reset();

    // Back-to-back: new vector every 8 cycles, output must be gapless.
    out_ready = 1'b1;
    gaps = 0; b0 = beats;
    for (int k = 0; k <= 4 * ROWS; k++) begin
      if (k % ROWS == 0 && k < 4 * ROWS) begin
        res_in = seq_vec(1000 + 16 * k); res_valid = '1;
      end else res_valid = '0;
      cyc();
      if (k >= 1 && !ov_s) gaps++;
    end
    chk("t5_gaps", gaps, 0);
    chk("t5_beats", beats - b0, 32);
    chk("t5_count", vec_count, 4);

    // Reset in the middle of a vector.
    b0 = beats;
    offer(seq_vec(500), 4, n);
    n = 0;
    while (beats - b0 < 4 && n < 20) begin cyc(); n++; end
    res_valid = '1;
    #2 rstn = 1'b0;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_count", vec_count, 0);
    chk("t6_busy", busy, 0);
    chk("t6_res_read", res_read, 0);
    @(negedge clk);
    do_reset();
    offer(seq_vec(700), 4, n);
    chk("t6_row0", out_row, 0);
    chk("t6_data0", out_data, 700);
    drain(20);
    chk("t6_count_after", vec_count, 1);

    // Randomized traffic with random backpressure and partial valids.
    do_reset();
    for (int r = 0; r < ROWS; r++) v[r] = $urandom;
    for (int i = 0; i < 400; i++) begin
      res_in = v;
      res_valid = ($urandom_range(3) != 0) ? 8'hFF : 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      cyc();
      if (took) for (int r = 0; r < ROWS; r++) v[r] = $urandom;
    end
    res_valid = '0;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
